// File: rtl/prio_rr_arbiter_4req_if.sv
`default_nettype none
// ============================================================================
//  Module   : prio_rr_arbiter_4req_if
//  Brief    : Request/grant bundle between 4 requesters and the arbiter.
//  Revision : 1.0
// ============================================================================
interface prio_rr_arbiter_4req_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       hold_expired;

    modport master (
        output req,
        input  gnt,
        input  gnt_id,
        input  gnt_valid,
        input  hold_expired
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_id,
        output gnt_valid,
        output hold_expired
    );
endinterface
`default_nettype wire

// File: rtl/prio_rr_arbiter_4req.sv
`default_nettype none
// ============================================================================
//  Module   : prio_rr_arbiter_4req
//  Brief    : 4-requester arbiter, fixed priority or round-robin, with an
//             optional per-winner hold limit. All outputs registered.
//  Revision : 1.0
// ============================================================================
module prio_rr_arbiter_4req #(
    parameter int MODE_RR  = 1,
    parameter int MAX_HOLD = 8
) (
    input  wire                            clk,
    input  wire                            rst_n,
    prio_rr_arbiter_4req_if.slave          arb
);

    localparam logic [7:0] c_max_hold = 8'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t     r_state;
    logic [3:0] r_gnt;
    logic [1:0] r_gnt_id;
    logic       r_gnt_valid;
    logic       r_hold_expired;
    logic [1:0] r_last_id;
    logic [7:0] r_hold_cnt;

    logic       w_any_req;
    logic [1:0] w_fix_id;
    logic [1:0] w_rr_id;
    logic [1:0] w_win_id;
    logic       w_owner_req;
    logic       w_limit_hit;

    assign w_any_req   = |arb.req;
    assign w_owner_req = arb.req[r_gnt_id];
    assign w_limit_hit = (c_max_hold != 8'd0) && (r_hold_cnt == c_max_hold);

    // Highest asserted index wins: later iterations overwrite earlier ones.
    always_comb begin
        w_fix_id = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (arb.req[i]) begin
                w_fix_id = 2'(i);
            end
        end
    end

    // Search upward from the slot after the previous owner, wrapping mod 4.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        found   = 1'b0;
        idx     = 2'd0;
        w_rr_id = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = r_last_id + 2'(k + 1);
            if (!found && arb.req[idx]) begin
                found   = 1'b1;
                w_rr_id = idx;
            end
        end
    end

    generate
        if (MODE_RR != 0) begin : g_rr
            assign w_win_id = w_rr_id;
        end else begin : g_fixed
            assign w_win_id = w_fix_id;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_gnt          <= 4'b0000;
            r_gnt_id       <= 2'd0;
            r_gnt_valid    <= 1'b0;
            r_hold_expired <= 1'b0;
            r_last_id      <= 2'd3;
            r_hold_cnt     <= 8'd0;
        end else begin
            case (r_state)
                IDLE, RELEASE: begin
                    r_hold_expired <= 1'b0;
                    if (w_any_req) begin
                        r_state     <= GRANT;
                        r_gnt       <= 4'b0001 << w_win_id;
                        r_gnt_id    <= w_win_id;
                        r_gnt_valid <= 1'b1;
                        r_hold_cnt  <= 8'd1;
                    end else begin
                        r_state     <= IDLE;
                        r_hold_cnt  <= 8'd0;
                    end
                end
                GRANT: begin
                    // A voluntary drop takes precedence over the hold limit.
                    if (!w_owner_req || w_limit_hit) begin
                        r_state        <= RELEASE;
                        r_gnt          <= 4'b0000;
                        r_gnt_valid    <= 1'b0;
                        r_hold_expired <= w_owner_req;
                        r_last_id      <= r_gnt_id;
                        r_hold_cnt     <= 8'd0;
                    end else if (r_hold_cnt != 8'hFF) begin
                        r_hold_cnt     <= r_hold_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state        <= IDLE;
                    r_gnt          <= 4'b0000;
                    r_gnt_valid    <= 1'b0;
                    r_hold_expired <= 1'b0;
                    r_hold_cnt     <= 8'd0;
                end
            endcase
        end
    end

    assign arb.gnt          = r_gnt;
    assign arb.gnt_id       = r_gnt_id;
    assign arb.gnt_valid    = r_gnt_valid;
    assign arb.hold_expired = r_hold_expired;

endmodule
`default_nettype wire

// File: tb/tb_prio_rr_arbiter_4req.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prio_rr_arbiter_4req
//  Brief    : Directed bench: RR instance (MAX_HOLD=4) and fixed instance
//             (MAX_HOLD=8) side by side. Observed tuple is
//             {gnt[3:0], gnt_id[1:0], gnt_valid, hold_expired}.
//  Revision : 1.0
// ============================================================================
module tb_prio_rr_arbiter_4req;

    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    prio_rr_arbiter_4req_if if_rr ();
    prio_rr_arbiter_4req_if if_fx ();

    prio_rr_arbiter_4req #(.MODE_RR(1), .MAX_HOLD(4)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (if_rr)
    );

    prio_rr_arbiter_4req #(.MODE_RR(0), .MAX_HOLD(8)) u_fx (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (if_fx)
    );

    function automatic logic [7:0] obs_rr();
        return {if_rr.gnt, if_rr.gnt_id, if_rr.gnt_valid, if_rr.hold_expired};
    endfunction

    function automatic logic [7:0] obs_fx();
        return {if_fx.gnt, if_fx.gnt_id, if_fx.gnt_valid, if_fx.hold_expired};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    initial begin
        logic [3:0] vecs [4];
        logic [7:0] exp_rr;
        logic [7:0] exp_fx;
        int         ph;
        int         id;

        // Reset held with all requests asserted.
        rst_n     = 1'b0;
        if_rr.req = 4'b1111;
        if_fx.req = 4'b1111;
        tick(); tick(); tick();
        chk("reset_rr", obs_rr(), 8'b0000_00_0_0);
        chk("reset_fx", obs_fx(), 8'b0000_00_0_0);

        // Release reset, requests stay 1111: RR rotates 0,1,2,3,0 in 4-cycle
        // slots with a 1-cycle expiry gap; fixed re-grants 3 every 8 cycles.
        rst_n = 1'b1;
        for (int t = 1; t <= 21; t++) begin
            tick();
            ph = (t - 1) % 5;
            id = ((t - 1) / 5) % 4;
            exp_rr = (ph < 4) ? {4'(1 << id), 2'(id), 2'b10} : {4'b0000, 2'(id), 2'b01};
            exp_fx = (((t - 1) % 9) < 8) ? 8'b1000_11_1_0 : 8'b0000_11_0_1;
            chk($sformatf("rot_rr_t%0d", t), obs_rr(), exp_rr);
            chk($sformatf("hold_fx_t%0d", t), obs_fx(), exp_fx);
        end

        // Drain both to IDLE; voluntary release shows no expiry pulse.
        if_rr.req = 4'b0000;
        if_fx.req = 4'b0000;
        tick();
        chk("drain_rel_rr", obs_rr(), 8'b0000_00_0_0);
        chk("drain_rel_fx", obs_fx(), 8'b0000_11_0_0);
        tick();

        // Fixed-priority encoder vectors from IDLE.
        vecs[0] = 4'b0001; vecs[1] = 4'b0011; vecs[2] = 4'b0111; vecs[3] = 4'b1111;
        for (int v = 0; v < 4; v++) begin
            if_fx.req = vecs[v];
            tick();
            chk($sformatf("enc_fx_%b", vecs[v]), obs_fx(), {4'(1 << v), 2'(v), 2'b10});
            if_fx.req = 4'b0000;
            tick();
            tick();
        end
        tick();
        chk("enc_fx_none", obs_fx(), 8'b0000_11_0_0);

        // Park RR last owner at 3 so the next search starts at requester 0.
        if_rr.req = 4'b1000;
        tick();
        chk("park_rr", obs_rr(), 8'b1000_11_1_0);
        if_rr.req = 4'b0000;
        tick();
        tick();

        // Requester 0 drops after 2 grant cycles; requester 2 follows after one gap.
        if_rr.req = 4'b0101;
        tick();
        chk("drop_rr_g1", obs_rr(), 8'b0001_00_1_0);
        tick();
        chk("drop_rr_g2", obs_rr(), 8'b0001_00_1_0);
        if_rr.req = 4'b0100;
        tick();
        chk("drop_rr_gap", obs_rr(), 8'b0000_00_0_0);
        tick();
        chk("drop_rr_next", obs_rr(), 8'b0100_10_1_0);

        // Same-edge: owner drops exactly where the hold limit is reached.
        tick(); tick(); tick();
        chk("same_rr_g4", obs_rr(), 8'b0100_10_1_0);
        if_rr.req = 4'b0000;
        tick();
        chk("same_rr_rel", obs_rr(), 8'b0000_10_0_0);
        tick();
        chk("same_rr_idle", obs_rr(), 8'b0000_10_0_0);

        // Reset in the middle of a grant to requester 1.
        if_rr.req = 4'b0010;
        tick();
        tick();
        chk("mid_rr_pre", obs_rr(), 8'b0010_01_1_0);
        rst_n     = 1'b0;
        if_rr.req = 4'b1111;
        if_fx.req = 4'b1111;
        tick();
        chk("mid_rr_rst", obs_rr(), 8'b0000_00_0_0);
        chk("mid_fx_rst", obs_fx(), 8'b0000_00_0_0);
        rst_n = 1'b1;
        tick();
        chk("mid_rr_restart", obs_rr(), 8'b0001_00_1_0);
        chk("mid_fx_restart", obs_fx(), 8'b1000_11_1_0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
